// File: rtl/persiana_pkg.sv
// Shared state encoding and default constants for the blind actuator.
package persiana_pkg;

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        ESPERA   = 3'd1,
        SUBIENDO = 3'd2,
        BAJANDO  = 3'd3,
        FALLO    = 3'd4
    } estado_t;

    localparam int POS_W_DEF    = 8;
    localparam int POS_MED_DEF  = 50;
    localparam int POS_MAX_DEF  = 100;
    localparam int TICK_DIV_DEF = 1000;
    localparam int DEAD_T_DEF   = 4;
    localparam int POS_RST_DEF  = 0;

    function automatic logic en_marcha(input estado_t e);
        return (e == SUBIENDO) || (e == BAJANDO);
    endfunction

endpackage

// File: rtl/divisor_pasos.sv
// Step prescaler: while run is high, wrap pulses once every TICK_DIV cycles.
module divisor_pasos #(
    parameter int TICK_DIV = 1000
) (
    input  logic reloj,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic wrap
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap = run && (cnt_q == CW'(TICK_DIV - 1));

    // clear wins over run so a partial step is discarded on the same edge the motor stops.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/persiana_actuador.sv
// Blind motor actuator: dead-time interlocked enable/direction, step position
// counter, limit sensors and a fault state for contradictory commands.
module persiana_actuador
    import persiana_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MED  = POS_MED_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DEAD_T   = DEAD_T_DEF,
    parameter int POS_RST  = POS_RST_DEF
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             subir,
    input  logic             bajar,
    output logic             motor_en,
    output logic             motor_dir,
    output logic             Sinf,
    output logic             Smed,
    output logic             Ssup,
    output logic [POS_W-1:0] pos,
    output logic             fallo,
    output logic [2:0]       estado_dbg
);

    localparam int DT_W = (DEAD_T > 1) ? $clog2(DEAD_T + 1) : 1;
    localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_MED = POS_W'(POS_MED);
    localparam logic [POS_W-1:0] P_RST = POS_W'(POS_RST);

    estado_t          state_q, state_d;
    logic             dir_obj_q, dir_obj_d;
    logic [DT_W-1:0]  cnt_dt_q, cnt_dt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap;
    logic             div_clear;
    logic             ambos;

    assign ambos = subir && bajar;

    divisor_pasos #(.TICK_DIV(TICK_DIV)) u_divisor (
        .reloj (reloj),
        .reset (reset),
        .run   (en_marcha(state_q)),
        .clear (div_clear),
        .wrap  (wrap)
    );

    assign div_clear = !en_marcha(state_d);

    always_comb begin
        state_d   = state_q;
        dir_obj_d = dir_obj_q;
        cnt_dt_d  = '0;
        pos_d     = pos_q;
        case (state_q)
            PARADO: begin
                if (ambos) begin
                    state_d = FALLO;
                end else if (subir && pos_q != P_MAX) begin
                    state_d   = ESPERA;
                    dir_obj_d = 1'b1;
                end else if (bajar && pos_q != '0) begin
                    state_d   = ESPERA;
                    dir_obj_d = 1'b0;
                end
            end
            ESPERA: begin
                if (ambos) begin
                    state_d = FALLO;
                end else if (!subir && !bajar) begin
                    state_d = PARADO;
                end else if (subir != dir_obj_q) begin
                    // Flip toward a limit already reached would drive past it; stop instead.
                    if (subir ? (pos_q == P_MAX) : (pos_q == '0)) begin
                        state_d = PARADO;
                    end else begin
                        dir_obj_d = subir;
                    end
                end else if (cnt_dt_q == DT_W'(DEAD_T - 1)) begin
                    state_d = dir_obj_q ? SUBIENDO : BAJANDO;
                end else begin
                    cnt_dt_d = cnt_dt_q + 1'b1;
                end
            end
            SUBIENDO: begin
                if (ambos) begin
                    state_d = FALLO;
                end else begin
                    if (wrap) pos_d = pos_q + 1'b1;
                    if (wrap && pos_d == P_MAX) begin
                        state_d = PARADO;
                    end else if (bajar) begin
                        state_d   = (pos_d != '0) ? ESPERA : PARADO;
                        dir_obj_d = 1'b0;
                    end else if (!subir) begin
                        state_d = PARADO;
                    end
                end
            end
            BAJANDO: begin
                if (ambos) begin
                    state_d = FALLO;
                end else begin
                    if (wrap) pos_d = pos_q - 1'b1;
                    if (wrap && pos_d == '0) begin
                        state_d = PARADO;
                    end else if (subir) begin
                        state_d   = (pos_d != P_MAX) ? ESPERA : PARADO;
                        dir_obj_d = 1'b1;
                    end else if (!bajar) begin
                        state_d = PARADO;
                    end
                end
            end
            FALLO: begin
                if (!subir && !bajar) state_d = PARADO;
            end
            default: state_d = PARADO;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q   <= PARADO;
            dir_obj_q <= 1'b0;
            cnt_dt_q  <= '0;
            pos_q     <= P_RST;
        end else begin
            state_q   <= state_d;
            dir_obj_q <= dir_obj_d;
            cnt_dt_q  <= cnt_dt_d;
            pos_q     <= pos_d;
        end
    end

    assign motor_en   = en_marcha(state_q);
    assign motor_dir  = (state_q == SUBIENDO);
    assign fallo      = (state_q == FALLO);
    assign pos        = pos_q;
    assign Sinf       = (pos_q == '0);
    assign Smed       = (pos_q == P_MED);
    assign Ssup       = (pos_q == P_MAX);
    assign estado_dbg = state_q;

endmodule

// File: tb/tb_persiana_actuador.sv
// Self-checking bench for persiana_actuador against a cycle-level behavioural model.
module tb_persiana_actuador;
    import persiana_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int DEAD_T   = 2;
    localparam int POS_MED  = 3;
    localparam int POS_MAX  = 6;
    localparam int POS_RST  = 0;
    localparam int POS_W    = 8;

    logic             reloj;
    logic             reset;
    logic             subir;
    logic             bajar;
    logic             motor_en;
    logic             motor_dir;
    logic             Sinf;
    logic             Smed;
    logic             Ssup;
    logic [POS_W-1:0] pos;
    logic             fallo;
    logic [2:0]       estado_dbg;

    persiana_actuador #(
        .POS_W    (POS_W),
        .POS_MED  (POS_MED),
        .POS_MAX  (POS_MAX),
        .TICK_DIV (TICK_DIV),
        .DEAD_T   (DEAD_T),
        .POS_RST  (POS_RST)
    ) dut (
        .reloj      (reloj),
        .reset      (reset),
        .subir      (subir),
        .bajar      (bajar),
        .motor_en   (motor_en),
        .motor_dir  (motor_dir),
        .Sinf       (Sinf),
        .Smed       (Smed),
        .Ssup       (Ssup),
        .pos        (pos),
        .fallo      (fallo),
        .estado_dbg (estado_dbg)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Model: mode 0 idle, 1 dead-time wait, 2 moving, 3 fault.
    int m_mode = 0;
    int m_pos  = POS_RST;
    int m_dir  = 0;
    int m_wait = 0;
    int m_prog = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit at_limit(input int d);
        return (d != 0) ? (m_pos == POS_MAX) : (m_pos == 0);
    endfunction

    task automatic modelo(input bit u, input bit d, input bit r);
        if (r) begin
            m_mode = 0; m_pos = POS_RST; m_prog = 0; m_wait = 0;
        end else if (m_mode == 3) begin
            if (!u && !d) m_mode = 0;
        end else if (u && d) begin
            m_mode = 3;
        end else if (m_mode == 0) begin
            if (u && !at_limit(1)) begin
                m_mode = 1; m_dir = 1; m_wait = DEAD_T;
            end else if (d && !at_limit(0)) begin
                m_mode = 1; m_dir = 0; m_wait = DEAD_T;
            end
        end else if (m_mode == 1) begin
            if (!u && !d) begin
                m_mode = 0;
            end else if (int'(u) != m_dir) begin
                if (at_limit(int'(u))) m_mode = 0;
                else begin m_dir = int'(u); m_wait = DEAD_T; end
            end else begin
                m_wait--;
                if (m_wait == 0) begin m_mode = 2; m_prog = 0; end
            end
        end else begin
            bit stepped = 0;
            bit want;
            m_prog++;
            if (m_prog == TICK_DIV) begin
                m_prog = 0;
                m_pos += (m_dir != 0) ? 1 : -1;
                stepped = 1;
            end
            want = (m_dir != 0) ? u : d;
            if (stepped && at_limit(m_dir)) begin
                m_mode = 0;
            end else if ((m_dir != 0) ? d : u) begin
                if (at_limit(1 - m_dir)) m_mode = 0;
                else begin m_mode = 1; m_dir = 1 - m_dir; m_wait = DEAD_T; end
            end else if (!want) begin
                m_mode = 0;
            end
        end
    endtask

    function automatic int estado_esperado();
        case (m_mode)
            0: return int'(PARADO);
            1: return int'(ESPERA);
            2: return (m_dir != 0) ? int'(SUBIENDO) : int'(BAJANDO);
            default: return int'(FALLO);
        endcase
    endfunction

    task automatic comparar();
        check("motor_en",  int'(motor_en),  int'(m_mode == 2));
        check("motor_dir", int'(motor_dir), int'(m_mode == 2 && m_dir != 0));
        check("fallo",     int'(fallo),     int'(m_mode == 3));
        check("pos",       int'(pos),       m_pos);
        check("Sinf",      int'(Sinf),      int'(m_pos == 0));
        check("Smed",      int'(Smed),      int'(m_pos == POS_MED));
        check("Ssup",      int'(Ssup),      int'(m_pos == POS_MAX));
        check("estado",    int'(estado_dbg), estado_esperado());
    endtask

    task automatic ciclo(input bit u, input bit d, input bit r);
        @(negedge reloj);
        subir = u; bajar = d; reset = r;
        @(posedge reloj);
        modelo(u, d, r);
        #1;
        comparar();
    endtask

    task automatic repetir(input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) ciclo(u, d, 1'b0);
    endtask

    task automatic hasta_pos(input bit u, input bit d, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_pos == target) break;
            ciclo(u, d, 1'b0);
        end
        check("alcanza_pos", int'(pos), target);
    endtask

    initial begin
        subir = 1'b0; bajar = 1'b0; reset = 1'b1;
        ciclo(0, 0, 1);
        ciclo(0, 0, 1);

        // Lowering at the bottom limit is ignored.
        repetir(0, 1, 5);

        // Full rise to the top, hold at top, then full descent.
        repetir(1, 0, 40);
        repetir(0, 0, 2);
        repetir(0, 1, 40);
        repetir(0, 0, 2);

        // Reversal mid-travel at pos 2.
        ciclo(0, 0, 1);
        hasta_pos(1, 0, 2, 40);
        repetir(0, 1, 12);
        repetir(0, 0, 2);

        // Contradictory commands while moving, then release.
        repetir(1, 0, 6);
        repetir(1, 1, 2);
        ciclo(0, 0, 0);
        repetir(0, 0, 2);

        // Withdraw mid-step at pos 4; partial step is lost.
        ciclo(0, 0, 1);
        hasta_pos(1, 0, 4, 60);
        repetir(1, 0, 2);
        ciclo(0, 0, 0);
        check("pos_tras_soltar", int'(pos), 4);
        repetir(1, 0, 12);
        repetir(0, 0, 2);

        // Reset mid-travel at pos 5.
        ciclo(0, 0, 1);
        hasta_pos(1, 0, 5, 60);
        ciclo(1, 0, 0);
        ciclo(1, 0, 1);
        check("pos_tras_reset", int'(pos), 0);
        repetir(0, 0, 2);

        // Random command segments with occasional resets.
        for (int s = 0; s < 400; s++) begin
            int sel = $urandom_range(0, 9);
            int len = $urandom_range(1, 30);
            bit u = (sel <= 3) || (sel == 8);
            bit d = (sel >= 4 && sel <= 8);
            if ($urandom_range(0, 49) == 0) ciclo(0, 0, 1);
            repetir(u, d, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/persiana_actuador.md
# persiana_actuador

Plant-side end of the blind-controller link: takes the `subir`/`bajar` motor commands produced by the blind FSM and returns the `Sinf`/`Smed`/`Ssup` position sensors it consumes. It drives a motor enable/direction pair with a dead-time interlock on every start and reversal. It tracks blind position with a step counter and raises a fault on contradictory commands. It sits between the controller and the motor driver pins, and doubles as a closed-loop model for controller verification.

## Interface
- `POS_W`, 8: position counter width.
- `POS_MED`, 50: step index reported as middle (`Smed`).
- `POS_MAX`, 100: fully-open step index (`Ssup`); must satisfy 0 < `POS_MED` < `POS_MAX` < 2^`POS_W`.
- `TICK_DIV`, 1000: clock cycles of motor travel per position step (≥ 2).
- `DEAD_T`, 4: motor-off cycles before any start or reversal (≥ 1).
- `POS_RST`, 0: position loaded at reset.
- `reloj` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `subir` in 1: raise command from the controller.
- `bajar` in 1: lower command from the controller.
- `motor_en` out 1: motor power enable.
- `motor_dir` out 1: 1 = up, 0 = down; meaningful only while `motor_en` = 1.
- `Sinf` out 1: `pos` == 0.
- `Smed` out 1: `pos` == `POS_MED`.
- `Ssup` out 1: `pos` == `POS_MAX`.
- `pos` out `POS_W`: current step position.
- `fallo` out 1: fault indication.

## Operation
- States: PARADO, ESPERA, SUBIENDO, BAJANDO, FALLO. A registered `dir_obj` holds the pending direction while in ESPERA.
- Reset sets state = PARADO, `pos` = `POS_RST`, dead-time counter = 0 and step divider = 0. Outputs after reset: `motor_en` = 0, `motor_dir` = 0, `fallo` = 0, and sensors decoded from `POS_RST`.
- **PARADO**
  - `subir` & `bajar` → FALLO.
  - `subir` & `pos` < `POS_MAX` → ESPERA with `dir_obj` = up.
  - `bajar` & `pos` > 0 → ESPERA with `dir_obj` = down.
  - A command pointing toward a limit already reached is ignored.
- **ESPERA**
  - `motor_en` = 0.
  - Dead-time counter runs 0..`DEAD_T`-1. At `DEAD_T`-1 the block enters SUBIENDO or BAJANDO according to `dir_obj`.
  - Both commands asserted → FALLO.
  - Both commands low → PARADO.
  - Opposite command alone → `dir_obj` flips and the counter restarts at 0.
- **SUBIENDO**, with these priorities:
  1. Both commands asserted → FALLO.
  2. Step divider wraps (`TICK_DIV`-1 → 0) → `pos`+1; if the new `pos` == `POS_MAX`, go to PARADO on the same edge.
  3. `bajar` alone → ESPERA with `dir_obj` = down (reversal).
  4. `subir` low → PARADO.
- **BAJANDO**: mirror of SUBIENDO. `pos`-1 per step, stops at 0, and reversal uses `subir`.
- Leaving SUBIENDO or BAJANDO clears the step divider; partial steps are discarded. `pos` never leaves [0, `POS_MAX`].
- **FALLO**: `motor_en` = 0, `fallo` = 1. Returns to PARADO only after a cycle with `subir` = `bajar` = 0.
- `motor_en` and `motor_dir` are decoded from the state register (Moore).
- Sensors are decoded combinationally from the registered `pos`. At most one sensor is high at a time.

## Timing
- A command sampled at edge n puts the block in ESPERA from n+1. `motor_en` rises at n+1+`DEAD_T`.
- First position step occurs `TICK_DIV` cycles after `motor_en` rises.
- Reaching a limit: `pos`, the limit sensor and `motor_en` = 0 all update on the same edge.
- Command withdrawal: `motor_en` falls one cycle after the command drops.
- Reversal: motor off for exactly `DEAD_T` cycles, never zero.
- Synchronous `reset` overrides every state, including mid-travel and mid-ESPERA. It takes effect at the next edge.

## Structure
- `persiana_pkg` holds the state enum encoding and the default constants for `POS_W`, `POS_MED`, `POS_MAX`, `TICK_DIV`, `DEAD_T`.
- One sub-module, `divisor_pasos`: a step prescaler with inputs run/clear and output `wrap`, parameterised by `TICK_DIV`.
- FSM, dead-time counter and position counter live in `persiana_actuador`.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEAD_T`=2, `POS_MED`=3, `POS_MAX`=6, `POS_RST`=0.
- Reset, then hold `subir` → `motor_en`=1 and `motor_dir`=1 two cycles after ESPERA entry. `pos` increments every 4 cycles. `Smed`=1 at `pos`=3. At `pos`=6, `Ssup`=1 and `motor_en`=0 on the same edge.
- Idle at `pos`=0, assert `bajar` → ignored: state stays PARADO, `motor_en`=0, `Sinf` stays 1.
- Moving up at `pos`=2, switch to `bajar` → `motor_en`=0 for exactly 2 cycles, then `motor_dir`=0. `pos` falls to 1 after 4 more cycles.
- Assert `subir` & `bajar` together while moving → `fallo`=1 and `motor_en`=0 the next cycle. Release both for one cycle → `fallo`=0, state PARADO.
- Drop `subir` 2 cycles into a step at `pos`=4 → `motor_en`=0 the next cycle and `pos` stays 4. Re-asserting needs a fresh 4-cycle step after dead time.
- Assert `reset` mid-travel at `pos`=5 → next edge: `pos`=0, `Sinf`=1, `motor_en`=0, `fallo`=0.
